// File: rtl/mapper_ctrl_if.sv
// Handshake and mapper-facing bus of the frame scheduler in front of the parallel symbol mapper.
// The slave side is the scheduler; the master side is whatever feeds config/bits and consumes the mapper strobes.
interface mapper_ctrl_if #(
  parameter int PHASES = 16,
  parameter int WIDTH  = 3,
  parameter int CNT_W  = 16
);
  logic                      cfg_valid_i;
  logic                      cfg_ready_o;
  logic [1:0]                cfg_mod_i;
  logic [CNT_W-1:0]          cfg_nsym_i;
  logic                      bits_valid_i;
  logic                      bits_ready_o;
  logic [PHASES*WIDTH-1:0]   bits_i_i;
  logic [PHASES*WIDTH-1:0]   bits_q_i;
  logic                      flush_i;
  logic                      map_enable_o;
  logic [1:0]                map_mod_o;
  logic [PHASES*WIDTH-1:0]   map_data_i_o;
  logic [PHASES*WIDTH-1:0]   map_data_q_o;
  logic                      out_valid_o;
  logic                      out_last_o;
  logic                      busy_o;
  logic                      err_cfg_o;

  modport slave (
    input  cfg_valid_i, cfg_mod_i, cfg_nsym_i, bits_valid_i, bits_i_i, bits_q_i, flush_i,
    output cfg_ready_o, bits_ready_o, map_enable_o, map_mod_o, map_data_i_o, map_data_q_o,
           out_valid_o, out_last_o, busy_o, err_cfg_o
  );

  modport master (
    output cfg_valid_i, cfg_mod_i, cfg_nsym_i, bits_valid_i, bits_i_i, bits_q_i, flush_i,
    input  cfg_ready_o, bits_ready_o, map_enable_o, map_mod_o, map_data_i_o, map_data_q_o,
           out_valid_o, out_last_o, busy_o, err_cfg_o
  );
endinterface

// File: rtl/mapper_ctrl.sv
// Frame scheduler for the parallel symbol mapper: accepts per-frame config, streams I/Q bit words,
// and only switches the mapper's modulation once every in-flight word has left the mapper pipeline.
module mapper_ctrl #(
  parameter int PHASES = 16,
  parameter int WIDTH  = 3,
  parameter int LAT    = 3,
  parameter int CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mapper_ctrl_if.slave  bus
);
  localparam int DW = PHASES * WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       mod_q, mod_d;
  logic [DW-1:0]    di_q, di_d;
  logic [DW-1:0]    dq_q, dq_d;
  logic             en_q, en_d;
  logic             err_q, err_d;
  logic [LAT:0]     vsh_q, vsh_d;
  logic [LAT:0]     lsh_q, lsh_d;
  logic             bits_hs;
  logic             cfg_bad;

  assign bits_hs = bus.bits_valid_i && (state_q == S_STREAM) && !bus.flush_i;
  assign cfg_bad = (bus.cfg_mod_i == 2'b01) || (bus.cfg_nsym_i == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    mod_d   = mod_q;
    di_d    = di_q;
    dq_d    = dq_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_valid_i) begin
            if (cfg_bad) begin
              err_d = 1'b1;
            end else begin
              pend_d  = bus.cfg_mod_i;
              cnt_d   = bus.cfg_nsym_i;
              state_d = (bus.cfg_mod_i == mod_q) ? S_STREAM : S_DRAIN;
            end
          end
        end
        // The mapper select may only move once nothing is left in its pipeline.
        S_DRAIN: begin
          if (vsh_q == '0) begin
            mod_d   = pend_q;
            state_d = S_STREAM;
          end
        end
        S_STREAM: begin
          if (bits_hs) begin
            en_d  = 1'b1;
            di_d  = bus.bits_i_i;
            dq_d  = bus.bits_q_i;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Valid and last tags ride alongside the mapper latency.
    vsh_d = {vsh_q[LAT-1:0], bits_hs};
    lsh_d = {lsh_q[LAT-1:0], bits_hs && (cnt_q == CNT_W'(1))};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      mod_q   <= '0;
      di_q    <= '0;
      dq_q    <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      vsh_q   <= '0;
      lsh_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mod_q   <= mod_d;
      di_q    <= di_d;
      dq_q    <= dq_d;
      en_q    <= en_d;
      err_q   <= err_d;
      vsh_q   <= vsh_d;
      lsh_q   <= lsh_d;
    end
  end

  assign bus.cfg_ready_o  = (state_q == S_IDLE);
  assign bus.bits_ready_o = (state_q == S_STREAM);
  assign bus.map_enable_o = en_q;
  assign bus.map_mod_o    = mod_q;
  assign bus.map_data_i_o = di_q;
  assign bus.map_data_q_o = dq_q;
  assign bus.out_valid_o  = vsh_q[LAT];
  assign bus.out_last_o   = lsh_q[LAT];
  assign bus.busy_o       = (state_q != S_IDLE) || (|vsh_q);
  assign bus.err_cfg_o    = err_q;
endmodule

// File: tb/tb_mapper_ctrl.sv
// Self-checking bench for mapper_ctrl: directed frames with random data and valid patterns,
// compared every cycle against a frame-level model built from accept history.
module tb_mapper_ctrl;
  localparam int PHASES = 16;
  localparam int WIDTH  = 3;
  localparam int LAT    = 3;
  localparam int CNT_W  = 16;
  localparam int DW     = PHASES * WIDTH;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  mapper_ctrl_if #(.PHASES(PHASES), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  mapper_ctrl #(.PHASES(PHASES), .WIDTH(WIDTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: a frame is "open" while words remain; outputs follow the accept history.
  int          cyc = 0, rst_cyc = 0, last_acc = -100, m_left = 0, acc_total = 0;
  logic [1:0]  m_mod = 2'b00, m_pend = 2'b00;
  bit          m_drain = 0, m_en = 0, m_err = 0, m_cfg_done = 0;
  logic [DW-1:0] m_di = '0, m_dq = '0;
  bit          acc_hist [8192];
  bit          lst_hist [8192];
  int          bv_mode = 0;

  // Observed event statistics per scenario.
  int en_cnt, ov_cnt, ol_cnt, err_cnt, first_en, first_ov, last_en_edge, chg_gap;
  logic [1:0] prev_mod = 2'b00;
  bit prev_ov = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hist(input int n);
    if (n < 0 || n <= rst_cyc) return 1'b0;
    return acc_hist[n];
  endfunction

  function automatic bit lhist(input int n);
    if (n < 0 || n <= rst_cyc) return 1'b0;
    return lst_hist[n];
  endfunction

  function automatic bit inflight(input int n);
    for (int k = 0; k <= LAT; k++) if (hist(n - k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_left = 0; m_mod = 2'b00; m_pend = 2'b00; m_drain = 0;
    m_en = 0; m_err = 0; m_di = '0; m_dq = '0;
    rst_cyc = cyc; last_acc = -100;
  endfunction

  function automatic void model_step();
    int n;
    cyc++;
    n = cyc;
    acc_hist[n] = 0; lst_hist[n] = 0;
    m_en = 0; m_err = 0; m_cfg_done = 0;
    if (!rst_i) begin
      model_reset();
      return;
    end
    if (bus.flush_i) begin
      m_left = 0; m_drain = 0;
    end else if (m_left == 0) begin
      if (bus.cfg_valid_i) begin
        m_cfg_done = 1;
        if (bus.cfg_mod_i == 2'b01 || bus.cfg_nsym_i == 0) m_err = 1;
        else begin
          m_left  = int'(bus.cfg_nsym_i);
          m_pend  = bus.cfg_mod_i;
          m_drain = (bus.cfg_mod_i != m_mod);
        end
      end
    end else if (m_drain) begin
      if (n - last_acc >= LAT + 2) begin
        m_mod = m_pend; m_drain = 0;
      end
    end else if (bus.bits_valid_i) begin
      acc_hist[n] = 1;
      lst_hist[n] = (m_left == 1);
      m_left--;
      m_en = 1; m_di = bus.bits_i_i; m_dq = bus.bits_q_i;
      last_acc = n; acc_total++;
    end
  endfunction

  task automatic compare_all();
    int n;
    n = cyc;
    check("cfg_ready",  bus.cfg_ready_o,  m_left == 0);
    check("bits_ready", bus.bits_ready_o, (m_left != 0) && !m_drain);
    check("map_enable", bus.map_enable_o, m_en);
    check("map_mod",    bus.map_mod_o,    m_mod);
    check("data_i",     bus.map_data_i_o, m_di);
    check("data_q",     bus.map_data_q_o, m_dq);
    check("out_valid",  bus.out_valid_o,  hist(n - LAT));
    check("out_last",   bus.out_last_o,   lhist(n - LAT));
    check("busy",       bus.busy_o,       (m_left != 0) || inflight(n));
    check("err_cfg",    bus.err_cfg_o,    m_err);
    if (bus.map_enable_o === 1'b1) begin
      en_cnt++; last_en_edge = n;
      if (first_en < 0) first_en = n;
    end
    if (bus.out_valid_o === 1'b1) begin
      ov_cnt++;
      if (first_ov < 0) first_ov = n;
    end
    if (bus.out_last_o === 1'b1) ol_cnt++;
    if (bus.err_cfg_o === 1'b1) err_cnt++;
    if (rst_i && bus.map_mod_o !== prev_mod) begin
      check("mod_chg_quiet", {prev_ov, bus.out_valid_o}, 2'b00);
      chg_gap = n - last_en_edge;
    end
    prev_mod = bus.map_mod_o;
    prev_ov  = bus.out_valid_o;
  endtask

  task automatic drive_next();
    if (m_cfg_done) bus.cfg_valid_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.bits_i_i = DW'({$urandom(), $urandom()});
    bus.bits_q_i = DW'({$urandom(), $urandom()});
    case (bv_mode)
      1:       bus.bits_valid_i = 1'b1;
      2:       bus.bits_valid_i = ~bus.bits_valid_i;
      3:       bus.bits_valid_i = 1'($urandom_range(0, 1));
      default: bus.bits_valid_i = 1'b0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
    drive_next();
  endtask

  task automatic clear_stats();
    en_cnt = 0; ov_cnt = 0; ol_cnt = 0; err_cnt = 0;
    first_en = -1; first_ov = -1; last_en_edge = -100; chg_gap = -1; acc_total = 0;
  endtask

  task automatic send_cfg(input logic [1:0] mod, input int nsym);
    bus.cfg_mod_i   = mod;
    bus.cfg_nsym_i  = CNT_W'(nsym);
    bus.cfg_valid_i = 1'b1;
    for (int i = 0; i < 200 && bus.cfg_valid_i; i++) tick();
    check("cfg_accept_timeout", bus.cfg_valid_i, 1'b0);
    bus.cfg_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (m_left == 0 && !inflight(cyc) && !bus.cfg_valid_i) break;
      tick();
    end
    check("idle_timeout", bus.busy_o, 1'b0);
  endtask

  initial begin
    bus.cfg_valid_i = 0; bus.cfg_mod_i = 0; bus.cfg_nsym_i = 0;
    bus.bits_valid_i = 0; bus.bits_i_i = 0; bus.bits_q_i = 0; bus.flush_i = 0;
    clear_stats();

    // Reset values held while rst_i is low.
    repeat (3) tick();
    rst_i = 1'b1;
    repeat (2) tick();

    // QPSK, 4 words, valid every cycle.
    clear_stats();
    bv_mode = 1;
    send_cfg(2'b00, 4);
    wait_idle(60);
    bv_mode = 0;
    check("s1_enables", en_cnt, 4);
    check("s1_valids",  ov_cnt, 4);
    check("s1_lasts",   ol_cnt, 1);
    check("s1_latency", first_ov - first_en, LAT);
    repeat (2) tick();

    // 16-QAM then 64-QAM offered immediately: drain before the select moves.
    clear_stats();
    bv_mode = 1;
    send_cfg(2'b10, 2);
    bus.cfg_mod_i = 2'b11; bus.cfg_nsym_i = CNT_W'(2); bus.cfg_valid_i = 1'b1;
    wait_idle(100);
    bv_mode = 0;
    check("s2_gap_ok",  chg_gap >= LAT + 2, 1'b1);
    check("s2_mod",     bus.map_mod_o, 2'b11);
    check("s2_valids",  ov_cnt, 4);
    check("s2_lasts",   ol_cnt, 2);
    repeat (2) tick();

    // Illegal configs.
    clear_stats();
    bv_mode = 1;
    send_cfg(2'b01, 5);
    tick();
    send_cfg(2'b00, 0);
    repeat (3) tick();
    bv_mode = 0;
    check("s3_errs",     err_cnt, 2);
    check("s3_enables",  en_cnt, 0);
    check("s3_cfgready", bus.cfg_ready_o, 1'b1);

    // QPSK, 8 words, toggling valid.
    clear_stats();
    bv_mode = 2;
    send_cfg(2'b00, 8);
    wait_idle(200);
    bv_mode = 0;
    check("s4_enables", en_cnt, 8);
    check("s4_valids",  ov_cnt, 8);
    check("s4_lasts",   ol_cnt, 1);
    repeat (2) tick();

    // Flush after 3 of 10 words.
    clear_stats();
    bv_mode = 1;
    send_cfg(2'b00, 10);
    for (int i = 0; i < 50 && acc_total < 3; i++) tick();
    bus.flush_i = 1'b1;
    tick();
    check("s5_idle_after_flush", bus.cfg_ready_o, 1'b1);
    bv_mode = 0;
    wait_idle(40);
    check("s5_enables", en_cnt, 3);
    check("s5_valids",  ov_cnt, 3);
    check("s5_lasts",   ol_cnt, 0);

    // Asynchronous reset mid-stream, then a fresh frame.
    clear_stats();
    bv_mode = 3;
    send_cfg(2'b10, 20);
    repeat (8) tick();
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("s6_async_mod", bus.map_mod_o, 2'b00);
    repeat (2) tick();
    rst_i = 1'b1;
    clear_stats();
    bv_mode = 1;
    send_cfg(2'b00, 3);
    wait_idle(60);
    check("s6_enables", en_cnt, 3);
    check("s6_lasts",   ol_cnt, 1);

    // Random back-to-back frames.
    clear_stats();
    bv_mode = 3;
    for (int f = 0; f < 12; f++) begin
      logic [1:0] md;
      case ($urandom_range(0, 2))
        0:       md = 2'b00;
        1:       md = 2'b10;
        default: md = 2'b11;
      endcase
      send_cfg(md, int'($urandom_range(1, 6)));
    end
    wait_idle(300);
    bv_mode = 0;
    check("s7_lasts", ol_cnt, 12);
    check("s7_valids_vs_accepts", ov_cnt, acc_total);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
